// File: rtl/cr_cceip_64_sa_export_pkg.sv
// Shared types and constants for the snapshot-bank telemetry exporter.
package cr_cceip_64_sa_export_pkg;

    localparam int unsigned SA_EXP_IDX_LSB = 50;
    localparam logic [3:0]  SA_EXP_HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHdr,
        StStream
    } sa_exp_state_e;

    // Counter beat layout; bits [55:50] start at SA_EXP_IDX_LSB.
    typedef struct packed {
        logic        torn;
        logic [6:0]  rsvd;
        logic [5:0]  idx;
        logic [49:0] cnt;
    } sa_exp_word_t;

    // Header beat: tag nibble, zero pad, frame count at frame start.
    function automatic logic [63:0] sa_exp_hdr_word(input logic [31:0] frame_cnt);
        return {SA_EXP_HDR_TAG, 28'd0, frame_cnt};
    endfunction

endpackage

// File: rtl/cr_cceip_64_sa_export_obuf.sv
// Single-entry output register for the export stream. A new beat is taken only when the
// register is empty or its current beat transfers this cycle, so data/first/last hold
// stable while the sink stalls and valid never drops without a transfer.
module cr_cceip_64_sa_export_obuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [63:0] data_i,
    input  logic        first_i,
    input  logic        last_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [63:0] data_o,
    output logic        first_o,
    output logic        last_o,
    output logic        xfer_o
);

    logic        valid_q;
    logic [63:0] data_q;
    logic        first_q;
    logic        last_q;
    logic        accept;

    assign xfer_o = valid_q & ready_i;
    assign accept = load_i & (~valid_q | ready_i);

    // Load a new beat when there is room, otherwise drain on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            first_q <= first_i;
            last_q  <= last_i;
        end else if (xfer_o) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/cr_cceip_64_sa_export.sv
// Snapshot-bank exporter: on each snapshot pulse, walks all counters and streams them out
// one 64-bit word per beat. Tracks completed frames and mid-frame snapshot overruns.
// Build option: CR_CCEIP_64_SA_EXPORT_HDR_EN prepends a header beat with the frame count.
module cr_cceip_64_sa_export
    import cr_cceip_64_sa_export_pkg::*;
#(
    parameter int unsigned NCnt    = 64,
    parameter int unsigned CntW    = 50,
    parameter int unsigned SnapLat = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_exp_en_i,
    input  logic            regs_sa_snap_i,
    input  logic [CntW-1:0] sa_snapshot_i [NCnt],
    output logic            exp_valid_o,
    input  logic            exp_ready_i,
    output logic [63:0]     exp_data_o,
    output logic            exp_first_o,
    output logic            exp_last_o,
    output logic            exp_busy_o,
    output logic [31:0]     exp_frame_cnt_o,
    output logic [15:0]     exp_overrun_cnt_o
);

    localparam int unsigned     IdxW     = $clog2(NCnt);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NCnt - 1);
    localparam logic [2:0]      WaitLast = 3'(SnapLat - 1);

    sa_exp_state_e   state_q;
    logic [IdxW-1:0] idx_q;        // index of the beat currently in the output register
    logic [2:0]      wait_q;
    logic            pending_q;
    logic            torn_q;
    logic [31:0]     frame_cnt_q;
    logic [15:0]     ovr_cnt_q;

    logic            busy, xfer, snap_acc, snap_ov, last_xfer, wait_done, torn_now;
    logic            ld_valid, ld_first, ld_last;
    logic [IdxW-1:0] ld_sel;
    logic [63:0]     ld_data;
    sa_exp_word_t    word;
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
    logic            ld_hdr;
`endif

    assign busy      = (state_q != StIdle);
    assign snap_acc  = regs_sa_snap_i & cfg_exp_en_i;
    assign snap_ov   = snap_acc & busy;
    assign last_xfer = xfer & (state_q == StStream) & (idx_q == IdxLast);
    assign wait_done = (state_q == StWait) & (wait_q == WaitLast);
    // A snap landing on the same edge as a load already taints that beat.
    assign torn_now  = torn_q | snap_ov;

    // Decide which beat (if any) enters the output register this cycle.
    always_comb begin
        ld_valid = 1'b0;
        ld_first = 1'b0;
        ld_sel   = '0;
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
        ld_hdr   = 1'b0;
`endif
        if (wait_done) begin
            ld_valid = 1'b1;
            ld_first = 1'b1;
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
            ld_hdr   = 1'b1;
`endif
        end
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
        else if (xfer && state_q == StHdr) begin
            ld_valid = 1'b1;
        end
`endif
        else if (xfer && state_q == StStream && idx_q != IdxLast) begin
            ld_valid = 1'b1;
            ld_sel   = idx_q + 1'b1;
        end
    end

    // Build the word for the selected counter (or the header) from the live snapshot bank.
    always_comb begin
        word      = '0;
        word.torn = torn_now;
        word.idx  = 6'(ld_sel);
        word.cnt  = 50'(sa_snapshot_i[ld_sel]);
        ld_data   = word;
        ld_last   = (ld_sel == IdxLast);
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
        if (ld_hdr) begin
            ld_data = sa_exp_hdr_word(frame_cnt_q);
            ld_last = 1'b0;
        end
`endif
    end

    // Frame FSM plus index, pending/torn flags and software-visible counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_q      <= '0;
            pending_q   <= 1'b0;
            torn_q      <= 1'b0;
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            if (ld_valid) begin
                idx_q <= ld_sel;
            end
            case (state_q)
                StIdle: begin
                    if (snap_acc) begin
                        state_q <= StWait;
                        wait_q  <= '0;
                    end
                end
                StWait: begin
                    if (wait_done) begin
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
                        state_q <= StHdr;
`else
                        state_q <= StStream;
`endif
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (last_xfer) begin
                        state_q <= (cfg_exp_en_i && (pending_q || snap_acc)) ? StWait : StIdle;
                        wait_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Pending is consumed at frame end; a snap on that same edge starts the next frame.
            if (!cfg_exp_en_i || last_xfer) begin
                pending_q <= 1'b0;
            end else if (snap_ov) begin
                pending_q <= 1'b1;
            end
            if (last_xfer) begin
                torn_q <= 1'b0;
            end else if (snap_ov) begin
                torn_q <= 1'b1;
            end
            if (last_xfer) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (snap_ov && ovr_cnt_q != 16'hFFFF) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    cr_cceip_64_sa_export_obuf u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ld_valid),
        .data_i  (ld_data),
        .first_i (ld_first),
        .last_i  (ld_last),
        .ready_i (exp_ready_i),
        .valid_o (exp_valid_o),
        .data_o  (exp_data_o),
        .first_o (exp_first_o),
        .last_o  (exp_last_o),
        .xfer_o  (xfer)
    );

    assign exp_busy_o        = busy;
    assign exp_frame_cnt_o   = frame_cnt_q;
    assign exp_overrun_cnt_o = ovr_cnt_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_export.sv
// Self-checking bench for cr_cceip_64_sa_export: scoreboard of expected beats built from the
// bench's own copy of the snapshot bank, table of single-frame vectors, and hand-written
// sequences for overrun, enable drop, reset and counter saturation.
module tb_cr_cceip_64_sa_export;

    localparam int SnapLat = 1;
`ifdef CR_CCEIP_64_SA_EXPORT_HDR_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        snap = 1'b0;
    logic        ready = 1'b1;
    logic [49:0] mem [64];
    logic        valid, first, last, busy;
    logic [63:0] data;
    logic [31:0] frame_cnt;
    logic [15:0] ovr_cnt;

    cr_cceip_64_sa_export dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_exp_en_i      (en),
        .regs_sa_snap_i    (snap),
        .sa_snapshot_i     (mem),
        .exp_valid_o       (valid),
        .exp_ready_i       (ready),
        .exp_data_o        (data),
        .exp_first_o       (first),
        .exp_last_o        (last),
        .exp_busy_o        (busy),
        .exp_frame_cnt_o   (frame_cnt),
        .exp_overrun_cnt_o (ovr_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        first;
        logic        last;
    } beat_t;

    typedef struct {
        int          pat;
        int          rdy;
        logic [31:0] exp_frames;
        logic [15:0] exp_ovr;
    } vec_t;

    beat_t       exp_q [$];
    vec_t        tbl [4];
    int          total = 0;
    int          bad = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b1;
    int          cyc = 0;
    int          last_cyc = 0;
    int          gap = 0;
    logic [31:0] frames_m = 0;
    logic [15:0] ov_m = 0;
    bit          hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [1:0]  hold_f;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fill(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0: mem[i] = 50'(i * 3);
                1: mem[i] = (i == 5) ? 50'h3_FFFF_FFFF_FFFF : 50'(i * 3);
                2: mem[i] = {18'($urandom), 32'($urandom)};
                default: mem[i] = {25'h155_5555, 25'h0AA_AAAA} ^ 50'(i);
            endcase
        end
    endfunction

    // Expected frame; beats with index >= torn_from carry torn=1.
    function automatic void push_frame(input int torn_from, input logic [31:0] fno);
        beat_t b;
        if (HdrEn) begin
            b.data  = {4'hA, 28'd0, fno};
            b.first = 1'b1;
            b.last  = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < 64; i++) begin
            logic [5:0] ix;
            ix      = 6'(i);
            b.data  = {(i >= torn_from), 7'd0, ix, mem[i]};
            b.first = !HdrEn && (i == 0);
            b.last  = (i == 63);
            exp_q.push_back(b);
        end
    endfunction

    // Ready pattern: mode 0 always ready, mode 1 toggles every cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rdy_mode == 1) ready = ~ready;
        else ready = 1'b1;
    end

    // Monitor: hold-stability on stalls, scoreboard compare on each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(valid), 64'd1);
                chk("hold_data", data, hold_d);
                chk("hold_flags", 64'({first, last}), 64'(hold_f));
            end
            hold_v = 1'b0;
            if (valid && ready) begin
                if (first) gap = cyc - last_cyc;
                if (last) last_cyc = cyc;
                if (mon_en) begin
                    chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_data", data, e.data);
                        chk("beat_flags", 64'({first, last}), 64'({e.first, e.last}));
                    end
                end
            end else if (valid) begin
                hold_v = 1'b1;
                hold_d = data;
                hold_f = {first, last};
            end
        end
    end

    // One-cycle snapshot pulse, entered and left on a falling edge.
    task automatic pulse();
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_in_time", 64'(ok), 64'd1);
    endtask

    // Returns on the falling edge where counter beat idx is about to transfer.
    task automatic wait_beat(input int idx);
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (valid && ready && !first && data[55:50] == 6'(idx)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("beat_reached", 64'(ok), 64'd1);
    endtask

    initial begin
        tbl[0] = '{pat: 0, rdy: 0, exp_frames: 32'd1, exp_ovr: 16'd0};
        tbl[1] = '{pat: 1, rdy: 1, exp_frames: 32'd2, exp_ovr: 16'd0};
        tbl[2] = '{pat: 2, rdy: 1, exp_frames: 32'd3, exp_ovr: 16'd0};
        tbl[3] = '{pat: 3, rdy: 0, exp_frames: 32'd4, exp_ovr: 16'd0};
        fill(0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_flags", 64'({first, last}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frames", 64'(frame_cnt), 64'd0);
        chk("rst_ovr", 64'(ovr_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames: latency, ordering, hold under stalls, boundary patterns.
        for (int r = 0; r < 4; r++) begin
            fill(tbl[r].pat);
            rdy_mode = tbl[r].rdy;
            @(negedge clk);
            push_frame(64, frames_m);
            pulse();
            chk("lat_cycle1_valid", 64'(valid), 64'd0);
            @(negedge clk);
            chk("lat_cycle2_valid", 64'(valid), 64'd1);
            chk("lat_busy", 64'(busy), 64'd1);
            wait_done(1000);
            frames_m++;
            chk("vec_frames", 64'(frame_cnt), 64'(tbl[r].exp_frames));
            chk("vec_ovr", 64'(ovr_cnt), 64'(tbl[r].exp_ovr));
        end
        rdy_mode = 0;
        fill(0);
        @(negedge clk);

        // Snap at beat 20: tail torn, then a clean follow-on frame after SnapLat+1 cycles.
        push_frame(21, frames_m);
        push_frame(64, frames_m + 1);
        pulse();
        wait_beat(20);
        pulse();
        ov_m++;
        wait_done(1000);
        frames_m += 2;
        chk("ovr_one", 64'(ovr_cnt), 64'(ov_m));
        chk("frames_after_ovr", 64'(frame_cnt), 64'(frames_m));
        chk("follow_on_gap", 64'(gap), 64'(SnapLat + 1));

        // Three snaps in one frame collapse to a single follow-on frame.
        push_frame(11, frames_m);
        push_frame(64, frames_m + 1);
        pulse();
        wait_beat(10);
        pulse();
        wait_beat(20);
        pulse();
        wait_beat(30);
        pulse();
        ov_m += 3;
        wait_done(1000);
        frames_m += 2;
        repeat (5) @(negedge clk);
        chk("multi_idle", 64'(busy), 64'd0);
        chk("multi_ovr", 64'(ovr_cnt), 64'(ov_m));
        chk("multi_frames", 64'(frame_cnt), 64'(frames_m));

        // Disabled: snaps ignored entirely.
        en = 1'b0;
        pulse();
        repeat (8) @(negedge clk);
        chk("dis_busy", 64'(busy), 64'd0);
        chk("dis_valid", 64'(valid), 64'd0);
        chk("dis_ovr", 64'(ovr_cnt), 64'(ov_m));
        en = 1'b1;
        @(negedge clk);

        // Enable dropped mid-frame after a pending snap: frame completes, no follow-on.
        push_frame(6, frames_m);
        pulse();
        wait_beat(5);
        pulse();
        ov_m++;
        wait_beat(10);
        en = 1'b0;
        wait_done(1000);
        frames_m++;
        repeat (5) @(negedge clk);
        chk("endrop_idle", 64'(busy), 64'd0);
        chk("endrop_frames", 64'(frame_cnt), 64'(frames_m));
        chk("endrop_ovr", 64'(ovr_cnt), 64'(ov_m));
        en = 1'b1;
        @(negedge clk);

        // Reset mid-frame returns everything to the reset state.
        push_frame(64, frames_m);
        pulse();
        wait_beat(30);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_frames", 64'(frame_cnt), 64'd0);
        chk("midrst_ovr", 64'(ovr_cnt), 64'd0);
        chk("midrst_data", data, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames_m = 0;
        ov_m = 0;
        @(negedge clk);
        push_frame(64, frames_m);
        pulse();
        wait_done(1000);
        frames_m++;
        chk("post_rst_frames", 64'(frame_cnt), 64'(frames_m));

        // Saturation: snap held high keeps counting overruns until the counter pins.
        mon_en = 1'b0;
        snap = 1'b1;
        repeat (65600) @(negedge clk);
        snap = 1'b0;
        chk("sat_ovr", 64'(ovr_cnt), 64'h0000_0000_0000_FFFF);
        repeat (10) @(negedge clk);
        chk("sat_busy", 64'(busy), 64'd1);
        pulse();
        @(negedge clk);
        chk("sat_hold", 64'(ovr_cnt), 64'h0000_0000_0000_FFFF);
        en = 1'b0;
        begin
            bit ok = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("sat_drain", 64'(ok), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
